cart_mem_sequencer: RTL and testbench

- Sits directly downstream of the mapper blocks (MMC1 and siblings).
- Takes the mapper-translated PRG and CHR linear addresses plus access strobes and serialises them onto the single-port cart memory controller (SDRAM/BRAM) request/ack bus.
- Returns read data to each side.
- Arbitrates PRG vs CHR round-robin, enforces allow gating, and recovers from a stalled memory with a timeout.

---
 rtl/cart_mem_sequencer_if.sv | 49 ++++
 rtl/cart_mem_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_cart_mem_sequencer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cart_mem_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : cart_mem_sequencer_if
// Description : Bus bundle for the cart memory sequencer. Holds the mapper
//               PRG/CHR access side and the single-port memory request/ack
//               side. The master modport is the sequencer's view.
// Revision    : 1.0 - initial release
// ============================================================================
interface cart_mem_sequencer_if;
  // PRG side (mapper -> sequencer, data back)
  logic        prg_req;
  logic [21:0] prg_addr;
  logic        prg_we;
  logic [7:0]  prg_wdata;
  logic        prg_allow;
  logic [7:0]  prg_rdata;
  logic        prg_busy;
  // CHR side (read only)
  logic        chr_req;
  logic [21:0] chr_addr;
  logic [7:0]  chr_rdata;
  logic        chr_busy;
  // Memory controller side
  logic        mem_req;
  logic [21:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  modport master (
    input  prg_req, prg_addr, prg_we, prg_wdata, prg_allow,
    output prg_rdata, prg_busy,
    input  chr_req, chr_addr,
    output chr_rdata, chr_busy,
    output mem_req, mem_addr, mem_we, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    output prg_req, prg_addr, prg_we, prg_wdata, prg_allow,
    input  prg_rdata, prg_busy,
    output chr_req, chr_addr,
    input  chr_rdata, chr_busy,
    input  mem_req, mem_addr, mem_we, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/cart_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cart_mem_sequencer
// Description : Serialises mapper PRG and CHR accesses onto a single-port
//               cart memory request/ack bus. One pending slot per side,
//               round-robin on conflicts, write gating via prg_allow, and a
//               WAIT_ACK timeout that aborts a stalled access.
// Revision    : 1.0 - initial release
// ============================================================================
module cart_mem_sequencer #(
  parameter int TIMEOUT   = 64,
  parameter bit CHR_FIRST = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  cart_mem_sequencer_if.master        bus,
  output logic                        err_overflow,
  output logic                        err_timeout
);

  localparam int                 CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic             rr_q, rr_d;           // 1 = CHR wins the next conflict
  logic             side_q, side_d;       // side in flight, 1 = CHR
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             prg_vld_q, prg_vld_d;
  logic [21:0]      prg_addr_q, prg_addr_d;
  logic             prg_we_q, prg_we_d;
  logic [7:0]       prg_wdata_q, prg_wdata_d;
  logic             chr_vld_q, chr_vld_d;
  logic [21:0]      chr_addr_q, chr_addr_d;

  logic             mem_req_q, mem_req_d;
  logic [21:0]      mem_addr_q, mem_addr_d;
  logic             mem_we_q, mem_we_d;
  logic [7:0]       mem_wdata_q, mem_wdata_d;

  logic [7:0]       prg_rdata_q, prg_rdata_d;
  logic [7:0]       chr_rdata_q, chr_rdata_d;
  logic             ovf_q, ovf_d;
  logic             to_q, to_d;

  logic             w_prg_take;
  logic             w_pick_chr;
  logic             w_prg_free;
  logic             w_chr_free;

  // Next-state: arbitration, access tracking and slot capture
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    side_d      = side_q;
    cnt_d       = cnt_q;
    prg_vld_d   = prg_vld_q;
    prg_addr_d  = prg_addr_q;
    prg_we_d    = prg_we_q;
    prg_wdata_d = prg_wdata_q;
    chr_vld_d   = chr_vld_q;
    chr_addr_d  = chr_addr_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    prg_rdata_d = prg_rdata_q;
    chr_rdata_d = chr_rdata_q;
    ovf_d       = ovf_q;
    to_d        = to_q;
    w_pick_chr  = 1'b0;
    w_prg_free  = 1'b0;
    w_chr_free  = 1'b0;

    // Disallowed writes vanish entirely; disallowed reads proceed
    w_prg_take = bus.prg_req && !(bus.prg_we && !bus.prg_allow);

    case (state_q)
      S_IDLE: begin
        // Nothing is in flight here, so any valid slot is pending. Using the
        // registered valid bits keeps same-cycle strobes out of this grant.
        if (prg_vld_q || chr_vld_q) begin
          if (prg_vld_q && chr_vld_q) begin
            w_pick_chr = rr_q;
            rr_d       = ~rr_q;
          end else begin
            w_pick_chr = chr_vld_q;
          end
          state_d   = S_WAIT;
          side_d    = w_pick_chr;
          cnt_d     = '0;
          mem_req_d = 1'b1;
          if (w_pick_chr) begin
            mem_addr_d  = chr_addr_q;
            mem_we_d    = 1'b0;
            mem_wdata_d = 8'h00;
          end else begin
            mem_addr_d  = prg_addr_q;
            mem_we_d    = prg_we_q;
            mem_wdata_d = prg_wdata_q;
          end
        end
      end
      S_WAIT: begin
        // The registered request falls on the ack edge, leaving an idle gap
        if (bus.mem_ack) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
          if (side_q) begin
            chr_rdata_d = bus.mem_rdata;
            w_chr_free  = 1'b1;
          end else begin
            if (!prg_we_q) prg_rdata_d = bus.mem_rdata;
            w_prg_free = 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          // Abort: reads return the open-bus value
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
          to_d      = 1'b1;
          if (side_q) begin
            chr_rdata_d = 8'hFF;
            w_chr_free  = 1'b1;
          end else begin
            if (!prg_we_q) prg_rdata_d = 8'hFF;
            w_prg_free = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A slot freed this cycle is still occupied for a strobe in the same
    // cycle, so freeing and capturing never coincide.
    if (w_prg_free) prg_vld_d = 1'b0;
    if (w_chr_free) chr_vld_d = 1'b0;

    if (w_prg_take) begin
      if (prg_vld_q) begin
        ovf_d = 1'b1;
      end else begin
        prg_vld_d   = 1'b1;
        prg_addr_d  = bus.prg_addr;
        prg_we_d    = bus.prg_we;
        prg_wdata_d = bus.prg_wdata;
      end
    end

    if (bus.chr_req) begin
      if (chr_vld_q) begin
        ovf_d = 1'b1;
      end else begin
        chr_vld_d  = 1'b1;
        chr_addr_d = bus.chr_addr;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rr_q        <= CHR_FIRST;
      side_q      <= 1'b0;
      cnt_q       <= '0;
      prg_vld_q   <= 1'b0;
      prg_addr_q  <= '0;
      prg_we_q    <= 1'b0;
      prg_wdata_q <= '0;
      chr_vld_q   <= 1'b0;
      chr_addr_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      prg_rdata_q <= 8'hFF;
      chr_rdata_q <= 8'hFF;
      ovf_q       <= 1'b0;
      to_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      side_q      <= side_d;
      cnt_q       <= cnt_d;
      prg_vld_q   <= prg_vld_d;
      prg_addr_q  <= prg_addr_d;
      prg_we_q    <= prg_we_d;
      prg_wdata_q <= prg_wdata_d;
      chr_vld_q   <= chr_vld_d;
      chr_addr_q  <= chr_addr_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      prg_rdata_q <= prg_rdata_d;
      chr_rdata_q <= chr_rdata_d;
      ovf_q       <= ovf_d;
      to_q        <= to_d;
    end
  end

  assign bus.prg_rdata = prg_rdata_q;
  assign bus.prg_busy  = prg_vld_q;
  assign bus.chr_rdata = chr_rdata_q;
  assign bus.chr_busy  = chr_vld_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign err_overflow  = ovf_q;
  assign err_timeout   = to_q;

endmodule
`default_nettype wire

// File: tb/tb_cart_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cart_mem_sequencer
// Description : Self-checking bench for cart_mem_sequencer. A transaction
//               level model predicts every output each cycle; directed
//               vectors add literal expectations from the test plan.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cart_mem_sequencer;

  localparam int TIMEOUT   = 8;
  localparam bit CHR_FIRST = 1'b1;

  logic clk;
  logic reset;
  logic err_overflow;
  logic err_timeout;

  cart_mem_sequencer_if bus ();

  cart_mem_sequencer #(
    .TIMEOUT   (TIMEOUT),
    .CHR_FIRST (CHR_FIRST)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .err_overflow (err_overflow),
    .err_timeout  (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;
  bit cmp_en;
  bit auto_ack;

  // Model: one memory access outstanding at most, one slot per side
  bit          m_req;
  logic [21:0] m_addr;
  bit          m_we;
  logic [7:0]  m_wdata;
  logic [7:0]  m_prd, m_crd;
  bit          m_ovf, m_to;
  bit          m_side_chr;
  int          m_age;
  bit          m_chr_turn;
  bit          p_full, c_full, p_we;
  logic [21:0] p_addr, c_addr;
  logic [7:0]  p_wd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic retire(input logic [7:0] d);
    m_req = 1'b0;
    if (m_side_chr) begin
      m_crd  = d;
      c_full = 1'b0;
    end else begin
      if (!p_we) m_prd = d;
      p_full = 1'b0;
    end
  endtask

  // Advance the model by one clock edge using the inputs about to be sampled
  task automatic model_step();
    bit p_occ, c_occ, take_chr;
    if (reset) begin
      m_req = 0; m_addr = '0; m_we = 0; m_wdata = '0;
      m_prd = 8'hFF; m_crd = 8'hFF; m_ovf = 0; m_to = 0;
      p_full = 0; c_full = 0; p_we = 0; p_addr = '0; c_addr = '0; p_wd = '0;
      m_age = 0; m_side_chr = 0; m_chr_turn = CHR_FIRST;
      return;
    end
    p_occ = p_full;
    c_occ = c_full;
    if (m_req) begin
      if (bus.mem_ack) begin
        retire(bus.mem_rdata);
      end else begin
        m_age++;
        if (m_age >= TIMEOUT) begin
          m_to = 1'b1;
          retire(8'hFF);
        end
      end
    end else if (p_occ || c_occ) begin
      take_chr = (p_occ && c_occ) ? m_chr_turn : c_occ;
      if (p_occ && c_occ) m_chr_turn = !m_chr_turn;
      m_req      = 1'b1;
      m_age      = 0;
      m_side_chr = take_chr;
      m_addr     = take_chr ? c_addr : p_addr;
      m_we       = take_chr ? 1'b0 : p_we;
      m_wdata    = p_wd;
    end
    if (bus.prg_req && !(bus.prg_we && !bus.prg_allow)) begin
      if (p_occ) m_ovf = 1'b1;
      else begin
        p_full = 1'b1; p_addr = bus.prg_addr; p_we = bus.prg_we; p_wd = bus.prg_wdata;
      end
    end
    if (bus.chr_req) begin
      if (c_occ) m_ovf = 1'b1;
      else begin
        c_full = 1'b1; c_addr = bus.chr_addr;
      end
    end
  endtask

  task automatic model_cmp();
    chk("mem_req", bus.mem_req, m_req);
    if (m_req) begin
      chk("mem_addr", bus.mem_addr, m_addr);
      chk("mem_we", bus.mem_we, m_we);
      if (m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
    end
    chk("prg_busy", bus.prg_busy, p_full);
    chk("chr_busy", bus.chr_busy, c_full);
    chk("prg_rdata", bus.prg_rdata, m_prd);
    chk("chr_rdata", bus.chr_rdata, m_crd);
    chk("err_overflow", err_overflow, m_ovf);
    chk("err_timeout", err_timeout, m_to);
  endtask

  // One clock: model follows the edge, then strobes clear and outputs compare
  task automatic cyc();
    model_step();
    @(negedge clk);
    bus.prg_req = 1'b0;
    bus.chr_req = 1'b0;
    bus.mem_ack = 1'b0;
    reset       = 1'b0;
    if (auto_ack && bus.mem_req) begin
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = bus.mem_addr[7:0] ^ 8'h5A;
    end
    if (cmp_en) model_cmp();
  endtask

  task automatic prg_strobe(input logic [21:0] a, input logic we, input logic [7:0] wd,
                            input logic allow);
    bus.prg_req = 1'b1; bus.prg_addr = a; bus.prg_we = we;
    bus.prg_wdata = wd; bus.prg_allow = allow;
  endtask

  task automatic chr_strobe(input logic [21:0] a);
    bus.chr_req = 1'b1; bus.chr_addr = a;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cmp_en = 0; auto_ack = 0;
    bus.prg_req = 0; bus.prg_addr = '0; bus.prg_we = 0; bus.prg_wdata = '0;
    bus.prg_allow = 0; bus.chr_req = 0; bus.chr_addr = '0;
    bus.mem_ack = 0; bus.mem_rdata = '0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b1; cyc();
    reset = 1'b1; cyc();
    cmp_en = 1'b1;

    // Reset values
    chk("rst_prg_rdata", bus.prg_rdata, 8'hFF);
    chk("rst_chr_rdata", bus.chr_rdata, 8'hFF);
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_busy", {bus.prg_busy, bus.chr_busy}, 2'b00);
    chk("rst_err", {err_overflow, err_timeout}, 2'b00);
    cyc();

    // PRG read, ack at T+4
    prg_strobe(22'h01_2345, 1'b0, 8'h00, 1'b1);
    cyc(); chk("t1_busy", bus.prg_busy, 1'b1); chk("t1_no_req", bus.mem_req, 1'b0);
    cyc(); chk("t1_req", bus.mem_req, 1'b1); chk("t1_addr", bus.mem_addr, 22'h01_2345);
    cyc(); chk("t1_req3", bus.mem_req, 1'b1);
    cyc(); chk("t1_req4", bus.mem_req, 1'b1);
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'hA5;
    cyc(); chk("t1_rdata", bus.prg_rdata, 8'hA5); chk("t1_busy_low", bus.prg_busy, 1'b0);
    chk("t1_req_low", bus.mem_req, 1'b0);

    // Simultaneous pairs, immediate acks
    auto_ack = 1'b1;
    prg_strobe(22'h00_0111, 1'b0, 8'h00, 1'b1); chr_strobe(22'h10_00AA);
    cyc();
    cyc(); chk("t2_chr_first", bus.mem_addr, 22'h10_00AA); chk("t2_req_a", bus.mem_req, 1'b1);
    cyc(); chk("t2_gap_a", bus.mem_req, 1'b0);
    cyc(); chk("t2_prg_second", bus.mem_addr, 22'h00_0111); chk("t2_req_b", bus.mem_req, 1'b1);
    cyc();
    prg_strobe(22'h00_0222, 1'b0, 8'h00, 1'b1); chr_strobe(22'h10_00BB);
    cyc();
    cyc(); chk("t2_prg_first", bus.mem_addr, 22'h00_0222); chk("t2_req_c", bus.mem_req, 1'b1);
    cyc(); chk("t2_gap_b", bus.mem_req, 1'b0);
    cyc(); chk("t2_chr_second", bus.mem_addr, 22'h10_00BB);
    cyc(); chk("t2_chr_rdata", bus.chr_rdata, 8'hE1); chk("t2_prg_rdata", bus.prg_rdata, 8'h78);
    auto_ack = 1'b0;

    // Disallowed write, then allowed write, then disallowed read
    prg_strobe(22'h00_2AAA, 1'b1, 8'hC3, 1'b0);
    cyc(); chk("t3_no_busy", bus.prg_busy, 1'b0);
    cyc(); chk("t3_no_req", bus.mem_req, 1'b0);
    cyc(); chk("t3_no_err", err_overflow, 1'b0);
    prg_strobe(22'h00_2AAA, 1'b1, 8'h3C, 1'b1);
    cyc();
    cyc(); chk("t3_req", bus.mem_req, 1'b1); chk("t3_we", bus.mem_we, 1'b1);
    chk("t3_wdata", bus.mem_wdata, 8'h3C);
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h99;
    cyc(); chk("t3_wr_keeps_rdata", bus.prg_rdata, 8'h78);
    prg_strobe(22'h00_0333, 1'b0, 8'h00, 1'b0);
    cyc(); chk("t3_rd_busy", bus.prg_busy, 1'b1);
    cyc(); chk("t3_rd_req", bus.mem_req, 1'b1);
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h5C;
    cyc(); chk("t3_rd_data", bus.prg_rdata, 8'h5C);

    // Overflow, including a strobe in the ack cycle
    chr_strobe(22'h20_0010);
    cyc(); cyc();
    cyc(); chr_strobe(22'h20_0020);
    cyc(); chk("t4_ovf", err_overflow, 1'b1);
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h77; chr_strobe(22'h20_0030);
    cyc(); chk("t4_rdata", bus.chr_rdata, 8'h77); chk("t4_req_low", bus.mem_req, 1'b0);
    cyc(); chk("t4_no_second", bus.mem_req, 1'b0);
    cyc(); chk("t4_no_third", bus.mem_req, 1'b0); chk("t4_busy", bus.chr_busy, 1'b0);

    // Timeout on a PRG read, then a late ack
    prg_strobe(22'h00_0444, 1'b0, 8'h00, 1'b1);
    cyc();
    for (int i = 0; i < TIMEOUT; i++) begin
      cyc(); chk("t5_req_held", bus.mem_req, 1'b1);
    end
    cyc(); chk("t5_req_drop", bus.mem_req, 1'b0); chk("t5_err", err_timeout, 1'b1);
    chk("t5_rdata_ff", bus.prg_rdata, 8'hFF); chk("t5_busy", bus.prg_busy, 1'b0);
    cyc(); cyc(); cyc();
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h11;
    cyc(); chk("t5_late_ack", bus.prg_rdata, 8'hFF); chk("t5_late_req", bus.mem_req, 1'b0);

    // Reset during WAIT_ACK
    chr_strobe(22'h30_0000);
    cyc();
    cyc(); chk("t6_req", bus.mem_req, 1'b1);
    cyc(); reset = 1'b1;
    cyc(); chk("t6_req_low", bus.mem_req, 1'b0);
    chk("t6_busy", {bus.prg_busy, bus.chr_busy}, 2'b00);
    chk("t6_rdata", {bus.prg_rdata, bus.chr_rdata}, 16'hFFFF);
    chk("t6_err", {err_overflow, err_timeout}, 2'b00);
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h42;
    cyc(); chk("t6_ack_ignored", bus.chr_rdata, 8'hFF); chk("t6_req_still_low", bus.mem_req, 1'b0);
    cyc(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
